// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus slice seen by the memory-mapped UART transmitter.
// The core drives address/strobe/data; the peripheral returns hit and read data.
interface mmio_uart_tx_if;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic        hit;
   logic [31:0] rd;

   modport master (
      output we,
      output a,
      output wd,
      input  hit,
      input  rd
   );

   modport slave (
      input  we,
      input  a,
      input  wd,
      output hit,
      output rd
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a store FIFO.
// TXDATA at BASE+0 queues a byte; STATUS at BASE+4 reports count/ovf/full/empty/busy.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          reset,
   mmio_uart_tx_if.slave bus,
   output logic          tx,
   output logic          busy
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e        state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q;

   logic          empty, full, baud_end, pop, push_req, push, ovf_clr;
   logic [7:0]    head, count_byte;
   logic [31:0]   status;
   logic          unused_bits;

   assign unused_bits = ^{bus.a[1:0], bus.wd[31:8]};

   assign bus.hit    = (bus.a[31:3] == BASE_ADDR[31:3]);
   assign empty      = (count_q == '0);
   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign baud_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
   assign head       = mem_q[rd_ptr_q];
   assign busy       = (state_q != StIdle) | ~empty;
   assign tx         = tx_q;
   assign count_byte = 8'(count_q);

   // The shifter loads from IDLE, or at the last STOP cycle to chain frames without a gap.
   assign pop      = ~empty & ((state_q == StIdle) | ((state_q == StStop) & baud_end));
   assign push_req = bus.we & bus.hit & ~bus.a[2];
   assign push     = push_req & (~full | pop);
   assign ovf_clr  = bus.we & bus.hit & bus.a[2] & bus.wd[3];

   assign status = {20'b0, count_byte, ovf_q, full, empty, busy};
   assign bus.rd = (bus.hit & bus.a[2]) ? status : 32'b0;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wd[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (push_req & ~push) ovf_q <= 1'b1;
         else if (ovf_clr)     ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               tx_q   <= 1'b1;
               baud_q <= '0;
               if (pop) begin
                  shift_q <= head;
                  state_q <= StStart;
                  tx_q    <= 1'b0;
               end
            end
            StStart: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= StData;
                  tx_q    <= shift_q[0];
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            StData: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     state_q <= StStop;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            StStop: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (pop) begin
                     shift_q <= head;
                     state_q <= StStart;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                     tx_q    <= 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mmio_uart_tx;
   localparam logic [31:0] TXDATA = 32'h1000_0000;
   localparam logic [31:0] STATUS = 32'h1000_0004;

   logic clk;
   logic reset;
   logic tx;
   logic busy;
   int   n_checks;
   int   n_errors;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .BASE_ADDR    (32'h1000_0000),
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .tx    (tx),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected tx samples for one frame, sample i at bit i.
   function automatic logic [39:0] frame(input logic [7:0] b);
      logic [39:0] f;
      for (int i = 0; i < 40; i++) begin
         int k;
         k = i / 4;
         if (k == 0)      f[i] = 1'b0;
         else if (k == 9) f[i] = 1'b1;
         else             f[i] = b[k-1];
      end
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      bus.we = 1'b1;
      bus.a  = addr;
      bus.wd = data;
      step();
      bus.we = 1'b0;
   endtask

   initial begin
      logic [79:0] obs;
      logic [79:0] exp_v;
      logic        quiet;
      int          guard;

      n_checks = 0;
      n_errors = 0;
      reset  = 1'b0;
      bus.we = 1'b0;
      bus.a  = 32'h0;
      bus.wd = 32'h0;

      // 1. reset
      step();
      step();
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      bus.a = STATUS;
      #1;
      check("reset_status", bus.rd, 32'h2);
      check("reset_hit", bus.hit, 1'b1);
      reset = 1'b1;
      step();

      // 2. single byte 0x55
      store(TXDATA, 32'h55);
      check("idle_after_push_tx", tx, 1'b1);
      obs = '0;
      for (int i = 0; i < 40; i++) begin
         step();
         obs[i] = tx;
      end
      check("frame_55", obs, {40'b0, frame(8'h55)});
      check("busy_in_stop", busy, 1'b1);
      step();
      check("busy_after_frame", busy, 1'b0);
      check("tx_after_frame", tx, 1'b1);

      // 3. back-to-back 0x01, 0x80
      store(TXDATA, 32'h01);
      bus.we = 1'b1;
      bus.wd = 32'h80;
      obs = '0;
      for (int i = 0; i < 80; i++) begin
         step();
         bus.we = 1'b0;
         obs[i] = tx;
      end
      exp_v = {frame(8'h80), frame(8'h01)};
      check("frames_01_80", obs, exp_v);
      step();
      check("busy_after_pair", busy, 1'b0);

      // 4. overflow: six consecutive stores while idle
      for (int i = 0; i < 6; i++) store(TXDATA, 32'h11 + i);
      bus.a = STATUS;
      #1;
      check("status_ovf", bus.rd, 32'h4D);
      store(STATUS, 32'h8);
      #1;
      check("status_ovf_clr", bus.rd, 32'h45);
      guard = 0;
      while (busy && guard < 400) begin
         step();
         guard++;
      end
      check("drain_busy", busy, 1'b0);
      #1;
      check("status_drained", bus.rd, 32'h2);

      // 5. decode
      bus.we = 1'b1;
      bus.a  = 32'h1000_0008;
      bus.wd = 32'hAA;
      #1;
      check("hit_out_hi", bus.hit, 1'b0);
      check("rd_out_hi", bus.rd, 32'h0);
      step();
      bus.we = 1'b1;
      bus.a  = 32'h0000_0000;
      #1;
      check("hit_out_lo", bus.hit, 1'b0);
      check("rd_out_lo", bus.rd, 32'h0);
      step();
      bus.we = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      check("decode_quiet", quiet, 1'b1);
      bus.a = 32'h1000_0003;
      #1;
      check("alias_hit", bus.hit, 1'b1);
      check("alias_rd", bus.rd, 32'h0);

      // 6. reset during DATA bit 3 of 0xA5 with 0x3C queued
      store(TXDATA, 32'hA5);
      store(TXDATA, 32'h3C);
      for (int i = 0; i < 17; i++) step();
      check("bit3_low", tx, 1'b0);
      reset = 1'b0;
      step();
      check("abort_tx", tx, 1'b1);
      check("abort_busy", busy, 1'b0);
      bus.a = STATUS;
      #1;
      check("abort_status", bus.rd, 32'h2);
      reset = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      check("no_residual", quiet, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
      $finish;
   end
endmodule
